// File: rtl/wishbone_timeout_guard.sv
// Wishbone bus watchdog. Passes a master's cycle straight through to the
// downstream slave. If a strobed access waits TIMEOUT cycles without an ack,
// the guard ends the access itself. It acks the master with ERR_DATA, drops
// the downstream cycle, records the address and counts the event.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   m_*_i / m_*_o       upstream (master-facing) wishbone port
//   s_*_o / s_*_i       downstream (slave-facing) wishbone port
//   err_clr_i           synchronous clear of err_count_o
//   timeout_o           one-cycle pulse per forced termination
//   err_adr_o           address of the most recent timed-out access
//   err_count_o         saturating count of timed-out accesses
module wishbone_timeout_guard #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned CNT_WIDTH = 11,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_we_i,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic [3:0]  m_sel_i,
  input  logic [31:0] m_adr_i,
  input  logic [31:0] m_dat_i,
  output logic [31:0] m_dat_o,
  output logic        m_ack_o,
  output logic        m_int_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_int_i,
  input  logic        err_clr_i,
  output logic        timeout_o,
  output logic [31:0] err_adr_o,
  output logic [15:0] err_count_o
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned EW = 16;
  localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [EW-1:0]        CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, ACTIVE, TO_ACK, DRAIN} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [AW-1:0]        err_adr;
  logic [EW-1:0]        err_count;
  logic                 timeout;

  logic pass;
  logic stalled;
  logic expire;

  // Pass-through only while out of reset and not terminating an access.
  assign pass    = rst && ((state == IDLE) || (state == ACTIVE));
  // A strobed access that the slave has not acked this cycle.
  assign stalled = m_cyc_i && m_stb_i && !s_ack_i;
  // Last permitted wait cycle; a real ack in this cycle clears stalled and wins.
  assign expire  = stalled && (wait_cnt == LAST_WAIT);

  // State, wait counter and error log.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      err_adr   <= '0;
      err_count <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, ACTIVE: begin
          if (expire) begin
            state    <= TO_ACK;
            wait_cnt <= '0;
            timeout  <= 1'b1;
          end else begin
            wait_cnt <= stalled ? wait_cnt + CNT_WIDTH'(1) : '0;
            state    <= m_cyc_i ? ACTIVE : IDLE;
          end
        end
        TO_ACK: begin
          state   <= DRAIN;
          err_adr <= m_adr_i;
          if (err_clr_i) begin
            err_count <= EW'(1);
          end else if (err_count != CNT_MAX) begin
            err_count <= err_count + EW'(1);
          end
        end
        DRAIN: begin
          if (!m_cyc_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Clear outside the forced-ack cycle; that cycle handles clear itself.
      if (err_clr_i && (state != TO_ACK)) begin
        err_count <= '0;
      end
    end
  end

  // Downstream port: mirrors the master, forced idle when not passing.
  assign s_we_o  = pass && m_we_i;
  assign s_cyc_o = pass && m_cyc_i;
  assign s_stb_o = pass && m_stb_i;
  assign s_sel_o = pass ? m_sel_i : SW'(0);
  assign s_adr_o = pass ? m_adr_i : AW'(0);
  assign s_dat_o = pass ? m_dat_i : DW'(0);

  // Upstream port: slave response, or the forced error response.
  assign m_ack_o = rst && ((pass && s_ack_i) || (state == TO_ACK));
  assign m_dat_o = !rst ? DW'(0) : (pass ? s_dat_i : ERR_DATA);
  assign m_int_o = rst && s_int_i;

  assign timeout_o   = timeout;
  assign err_adr_o   = err_adr;
  assign err_count_o = err_count;

endmodule

// File: tb/tb_wishbone_timeout_guard.sv
// Bench for wishbone_timeout_guard (TIMEOUT=8): directed vector table,
// hand-written corner sequences, then random traffic against a reference model.
module tb_wishbone_timeout_guard;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_we_i, m_cyc_i, m_stb_i;
  logic [3:0]  m_sel_i;
  logic [31:0] m_adr_i, m_dat_i;
  logic [31:0] m_dat_o;
  logic        m_ack_o, m_int_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_int_i;
  logic        err_clr_i;
  logic        timeout_o;
  logic [31:0] err_adr_o;
  logic [15:0] err_count_o;

  wishbone_timeout_guard #(.TIMEOUT(TO), .CNT_WIDTH(4), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_int_o(m_int_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_int_i(s_int_i), .err_clr_i(err_clr_i),
    .timeout_o(timeout_o), .err_adr_o(err_adr_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Side-band values copied onto the bus at each cycle's drive point.
  logic        p_we = 1'b0;
  logic [3:0]  p_sel = 4'hF;
  logic [31:0] p_adr = 32'h1000_0040;
  logic [31:0] p_mdat = 32'h0BAD_F00D;
  logic        p_sint = 1'b0;
  bit          rnd = 1'b0;

  // Outputs captured mid-cycle by run_cycle.
  logic        sn_ack, sn_scyc, sn_to;
  logic [31:0] sn_dat, sn_adr;
  logic [15:0] sn_cnt;

  // Reference model: phase 0 = forwarding, 1 = forced ack, 2 = waiting for cyc to drop.
  int          md_phase;
  int          md_waited;
  logic [31:0] md_adr;
  int          md_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [153:0] act, input logic [153:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    md_phase  = 0;
    md_waited = 0;
    md_adr    = 32'h0;
    md_cnt    = 0;
  endtask

  function automatic logic [153:0] actual_outs();
    return {m_ack_o, m_dat_o, m_int_o, s_we_o, s_cyc_o, s_stb_o, s_sel_o,
            s_adr_o, s_dat_o, timeout_o, err_adr_o, err_count_o};
  endfunction

  function automatic logic [153:0] model_outs();
    logic fwd;
    logic forced;
    fwd    = (md_phase == 0);
    forced = (md_phase == 1);
    return {fwd ? s_ack_i : forced, fwd ? s_dat_i : ERR, s_int_i,
            fwd & m_we_i, fwd & m_cyc_i, fwd & m_stb_i, fwd ? m_sel_i : 4'h0,
            fwd ? m_adr_i : 32'h0, fwd ? m_dat_i : 32'h0, forced, md_adr, 16'(md_cnt)};
  endfunction

  // Advance the model by one clock using the inputs held over that edge.
  task automatic model_update();
    int old;
    old = md_phase;
    if (old == 0) begin
      if (m_cyc_i && m_stb_i && !s_ack_i) begin
        md_waited++;
        if (md_waited >= TO) begin
          md_phase  = 1;
          md_waited = 0;
        end
      end else begin
        md_waited = 0;
      end
    end else if (old == 1) begin
      md_adr   = m_adr_i;
      md_cnt   = err_clr_i ? 1 : ((md_cnt < 65535) ? md_cnt + 1 : 65535);
      md_phase = 2;
    end else if (!m_cyc_i) begin
      md_phase = 0;
    end
    if (old != 1 && err_clr_i) md_cnt = 0;
  endtask

  // One clock: drive at negedge, compare against the model, then step the model.
  task automatic run_cycle(input logic cyc, input logic stb, input logic ack,
                           input logic [31:0] dat, input logic clr);
    @(negedge clk);
    if (rnd) begin
      p_we   = 1'($urandom);
      p_sel  = 4'($urandom);
      p_adr  = $urandom;
      p_mdat = $urandom;
      p_sint = 1'($urandom);
    end
    m_cyc_i = cyc; m_stb_i = stb; s_ack_i = ack; s_dat_i = dat; err_clr_i = clr;
    m_we_i = p_we; m_sel_i = p_sel; m_adr_i = p_adr; m_dat_i = p_mdat; s_int_i = p_sint;
    #1;
    sn_ack = m_ack_o; sn_dat = m_dat_o; sn_scyc = s_cyc_o;
    sn_to = timeout_o; sn_cnt = err_count_o; sn_adr = err_adr_o;
    chk_vec("model", actual_outs(), model_outs());
    @(posedge clk);
    model_update();
  endtask

  // Stall to expiry, forced-ack cycle (optional clear), then one drain cycle with cyc low.
  task automatic do_timeout(input logic clr_at_to, input string tag);
    for (int i = 0; i < TO; i++) run_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0, clr_at_to);
    chk({tag, "_forced_ack"}, 32'(sn_ack), 32'd1);
    chk({tag, "_pulse"}, 32'(sn_to), 32'd1);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  typedef struct {
    logic        cyc, stb, ack;
    logic [31:0] dat;
    logic        e_ack;
    logic [31:0] e_dat;
    logic        e_scyc, e_to;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic cyc, input logic stb, input logic ack,
                         input logic [31:0] dat, input logic e_ack,
                         input logic [31:0] e_dat, input logic e_scyc,
                         input logic e_to, input logic [15:0] e_cnt);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.ack = ack; v.dat = dat;
    v.e_ack = e_ack; v.e_dat = e_dat; v.e_scyc = e_scyc; v.e_to = e_to; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  task automatic build_table();
    // normal read, acked in cycle 3
    for (int i = 0; i < 3; i++) add_row(1, 1, 0, 32'h0, 0, 32'h0, 1, 0, 16'd0);
    add_row(1, 1, 1, 32'h12345678, 1, 32'h12345678, 1, 0, 16'd0);
    add_row(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 16'd0);
    // timeout in cycle 8, late ack swallowed, then a normal access
    for (int i = 0; i < 8; i++) add_row(1, 1, 0, 32'h0, 0, 32'h0, 1, 0, 16'd0);
    add_row(1, 1, 0, 32'h0, 1, ERR, 0, 1, 16'd0);
    add_row(1, 1, 1, 32'h55, 0, ERR, 0, 0, 16'd1);
    add_row(0, 0, 0, 32'h0, 0, ERR, 0, 0, 16'd1);
    add_row(1, 1, 1, 32'hCAFE0001, 1, 32'hCAFE0001, 1, 0, 16'd1);
    add_row(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 16'd1);
    // ack in cycle 7 wins; next beat gets a fresh 8-cycle window
    for (int i = 0; i < 7; i++) add_row(1, 1, 0, 32'h0, 0, 32'h0, 1, 0, 16'd1);
    add_row(1, 1, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1, 0, 16'd1);
    for (int i = 0; i < 8; i++) add_row(1, 1, 0, 32'h0, 0, 32'h0, 1, 0, 16'd1);
    add_row(1, 1, 0, 32'h0, 1, ERR, 0, 1, 16'd1);
    add_row(0, 0, 0, 32'h0, 0, ERR, 0, 0, 16'd2);
    add_row(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 16'd2);
  endtask

  initial begin
    int burst;
    rst = 1'b0;
    m_we_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1; m_sel_i = 4'hF;
    m_adr_i = 32'h1234_0000; m_dat_i = 32'h0; s_dat_i = 32'h0;
    s_ack_i = 1'b1; s_int_i = 1'b1; err_clr_i = 1'b0;
    model_reset();

    // reset state, with a live request showing the gating
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("rst_m_ack", 32'(m_ack_o), 32'd0);
    chk("rst_m_int", 32'(m_int_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_err_adr", err_adr_o, 32'd0);
    chk("rst_err_cnt", 32'(err_count_o), 32'd0);
    @(negedge clk);
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = 1'b0; s_int_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    build_table();
    foreach (tbl[i]) begin
      run_cycle(tbl[i].cyc, tbl[i].stb, tbl[i].ack, tbl[i].dat, 1'b0);
      chk($sformatf("tbl%0d_m_ack", i), 32'(sn_ack), 32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_m_dat", i), sn_dat, tbl[i].e_dat);
      chk($sformatf("tbl%0d_s_cyc", i), 32'(sn_scyc), 32'(tbl[i].e_scyc));
      chk($sformatf("tbl%0d_timeout", i), 32'(sn_to), 32'(tbl[i].e_to));
      chk($sformatf("tbl%0d_err_cnt", i), 32'(sn_cnt), 32'(tbl[i].e_cnt));
    end

    // error address capture
    p_adr = 32'hABCD_0010;
    do_timeout(1'b0, "adr");
    chk("err_adr_capture", sn_adr, 32'hABCD_0010);
    chk("err_cnt_3", 32'(sn_cnt), 32'd3);
    p_adr = 32'h1000_0040;

    // plain clear, then clear coinciding with the forced ack
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("clr_to_zero", 32'(sn_cnt), 32'd0);
    do_timeout(1'b0, "t1");
    chk("cnt_after_t1", 32'(sn_cnt), 32'd1);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    do_timeout(1'b1, "clr_at_to");
    chk("clr_with_to", 32'(sn_cnt), 32'd1);

    // saturation: preload just below the ceiling
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    force dut.err_count = 16'hFFFE;
    #1;
    release dut.err_count;
    md_cnt = 65534;
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("preload_held", 32'(sn_cnt), 32'h0000FFFE);
    do_timeout(1'b0, "sat1");
    chk("sat_reach", 32'(sn_cnt), 32'h0000FFFF);
    do_timeout(1'b0, "sat2");
    chk("sat_hold", 32'(sn_cnt), 32'h0000FFFF);

    // asynchronous reset in cycle 5 of a stalled access
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    s_int_i = 1'b1;
    rst = 1'b0;
    #1;
    chk("mid_rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("mid_rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("mid_rst_m_ack", 32'(m_ack_o), 32'd0);
    chk("mid_rst_m_int", 32'(m_int_o), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_count_o), 32'd0);
    model_reset();
    @(negedge clk);
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_int_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk($sformatf("post_rst%0d_ack", i), 32'(sn_ack), 32'd0);
      chk($sformatf("post_rst%0d_to", i), 32'(sn_to), 32'd0);
    end
    chk("post_rst_err_cnt", 32'(sn_cnt), 32'd0);

    // random traffic with occasional long stalls
    rnd = 1'b1;
    burst = 0;
    for (int n = 0; n < 4000; n++) begin
      logic c, s, a, clr;
      if (burst > 0) begin
        burst--;
        c = 1'b1; s = 1'b1; a = 1'b0;
      end else begin
        c = ($urandom % 8) != 0;
        s = ($urandom % 3) != 0;
        a = ($urandom % 4) == 0;
        if (($urandom % 25) == 0) burst = int'($urandom_range(5, 12));
      end
      clr = ($urandom % 60) == 0;
      run_cycle(c, s, a, $urandom, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
